// File: rtl/p_mul_seq_pkg.sv
// p_mul_seq_pkg: shared FSM type and pack-width helpers for the iterative packed multiplier.
package p_mul_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Widest pw vector any legal XLEN needs (XLEN=64 -> 6 bits); callers zero-extend.
    localparam int unsigned PW_MAX_W = 8;

    // One-hot pw bit indices; lane width is XLEN >> index.
    localparam int unsigned PW_IDX_XLEN    = 0;
    localparam int unsigned PW_IDX_HALF    = 1;
    localparam int unsigned PW_IDX_QUARTER = 2;

    // Lane width selected by a one-hot pw, or 0 when pw is zero / not one-hot.
    function automatic int unsigned pw_lane_width(input logic [PW_MAX_W-1:0] pw,
                                                  input int unsigned          xlen);
        int unsigned w;
        int unsigned ones;
        w    = 0;
        ones = 0;
        for (int unsigned i = PW_IDX_XLEN; i < PW_MAX_W; i++) begin
            if (pw[i]) begin
                ones++;
                w = xlen >> i;
            end
        end
        return (ones == 1) ? w : 0;
    endfunction

    // RUN cycles needed for one operation; an illegal pw still takes a single RUN cycle.
    function automatic int unsigned pw_iter_count(input logic [PW_MAX_W-1:0] pw,
                                                  input int unsigned          xlen,
                                                  input int unsigned          bpc);
        int unsigned n;
        n = pw_lane_width(pw, xlen) / bpc;
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/p_mul_seq_lane_mask.sv
// p_mul_seq_lane_mask: lane boundary masks over the 2*XLEN lane-contiguous working layout,
// where lane i of width w occupies bits [2w*i +: 2w].
module p_mul_seq_lane_mask
    import p_mul_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BPC  = 1,
    parameter int unsigned PW_W = $clog2(XLEN)
) (
    input  logic [PW_W-1:0]   pw,
    output logic [2*XLEN-1:0] lane_msb,
    output logic [2*XLEN-1:0] lane_top,
    output logic [2*XLEN-1:0] lane_bot
);

    logic [PW_W-1:0][2*XLEN-1:0] msb_p;
    logic [PW_W-1:0][2*XLEN-1:0] top_p;
    logic [PW_W-1:0][2*XLEN-1:0] bot_p;

    for (genvar p = 0; p < PW_W; p++) begin : g_pw
        localparam int unsigned LW2 = 2 * (XLEN >> p);
        for (genvar k = 0; k < 2 * XLEN; k++) begin : g_bit
            assign msb_p[p][k] = ((k % LW2) == LW2 - 1);
            assign top_p[p][k] = ((k % LW2) >= LW2 - BPC);
            assign bot_p[p][k] = ((k % LW2) < BPC);
        end
    end

    // pw is one-hot or zero here, so an OR of the enabled rows selects one mask set.
    always_comb begin
        lane_msb = '0;
        lane_top = '0;
        lane_bot = '0;
        for (int p = 0; p < PW_W; p++) begin
            if (pw[p]) begin
                lane_msb |= msb_p[p];
                lane_top |= top_p[p];
                lane_bot |= bot_p[p];
            end
        end
    end

endmodule

// File: rtl/p_mul_seq.sv
// p_mul_seq: iterative packed-SIMD integer / carry-less multiplier, BPC multiplier bits per
// lane per cycle. Optional build macro P_MUL_SEQ_EARLY_EXIT_EN finishes RUN as soon as every
// lane's remaining multiplier bits are zero.
module p_mul_seq
    import p_mul_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BPC  = 1,
    parameter int unsigned PW_W = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            valid,
    output logic            ready,
    input  logic            mul_l,
    input  logic            mul_h,
    input  logic            clmul,
    input  logic [PW_W-1:0] pw,
    input  logic [XLEN-1:0] crs1,
    input  logic [XLEN-1:0] crs2,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       last_q;
    logic [PW_W-1:0]        pw_q;
    logic                   clmul_q;
    logic                   mul_l_q;
    logic                   mul_h_q;
    logic [2*XLEN-1:0]      mcand_q;
    logic [2*XLEN-1:0]      mplier_q;
    logic [2*XLEN-1:0]      acc_q;

    logic [PW_W-1:0]        pw_sel;
    logic [CNT_W-1:0]       last_d;
    logic [2*XLEN-1:0]      load_a;
    logic [2*XLEN-1:0]      load_b;
    logic [2*XLEN-1:0]      acc_d;
    logic [2*XLEN-1:0]      mcand_d;
    logic [2*XLEN-1:0]      mplier_d;
    logic [2*XLEN-1:0]      pp;
    logic [XLEN-1:0]        acc_lo;
    logic [XLEN-1:0]        acc_hi;
    logic                   run_last;

    logic [2*XLEN-1:0]      lane_msb;
    logic [2*XLEN-1:0]      lane_top;
    logic [2*XLEN-1:0]      lane_bot;

    logic [PW_W-1:0][2*XLEN-1:0]          spread_a;
    logic [PW_W-1:0][2*XLEN-1:0]          spread_b;
    logic [PW_W-1:0][XLEN-1:0]            unpack_lo;
    logic [PW_W-1:0][XLEN-1:0]            unpack_hi;
    logic [BPC-1:0][PW_W-1:0][2*XLEN-1:0] bcast;
    logic [BPC-1:0][2*XLEN-1:0]           bsel;

    // An illegal pw loads as zero: operands, masks and result then all stay zero.
    assign pw_sel = (pw_lane_width(PW_MAX_W'(pw), XLEN) != 0) ? pw : '0;
    assign last_d = CNT_W'(pw_iter_count(PW_MAX_W'(pw), XLEN, BPC) - 1);

    p_mul_seq_lane_mask #(
        .XLEN (XLEN),
        .BPC  (BPC),
        .PW_W (PW_W)
    ) u_lane_mask (
        .pw       (pw_q),
        .lane_msb (lane_msb),
        .lane_top (lane_top),
        .lane_bot (lane_bot)
    );

    // Per pack width: packed <-> lane-contiguous layout, and per-lane multiplier bit broadcast.
    for (genvar p = 0; p < PW_W; p++) begin : g_pw
        localparam int unsigned LW = XLEN >> p;
        localparam int unsigned NL = XLEN / LW;
        for (genvar l = 0; l < NL; l++) begin : g_lane
            assign spread_a[p][2*LW*l +: 2*LW] = {{LW{1'b0}}, crs1[LW*l +: LW]};
            assign spread_b[p][2*LW*l +: 2*LW] = {{LW{1'b0}}, crs2[LW*l +: LW]};
            assign unpack_lo[p][LW*l +: LW]    = acc_q[2*LW*l +: LW];
            assign unpack_hi[p][LW*l +: LW]    = acc_q[2*LW*l + LW +: LW];
            for (genvar j = 0; j < BPC; j++) begin : g_bit
                assign bcast[j][p][2*LW*l +: 2*LW] = {(2*LW){mplier_q[2*LW*l + j]}};
            end
        end
    end

    // Select the layout views for the incoming (pw_sel) and the running (pw_q) pack width.
    always_comb begin
        load_a = '0;
        load_b = '0;
        acc_lo = '0;
        acc_hi = '0;
        bsel   = '0;
        for (int p = 0; p < PW_W; p++) begin
            if (pw_sel[p]) begin
                load_a |= spread_a[p];
                load_b |= spread_b[p];
            end
            if (pw_q[p]) begin
                acc_lo |= unpack_lo[p];
                acc_hi |= unpack_hi[p];
                for (int j = 0; j < BPC; j++) begin
                    bsel[j] |= bcast[j][p];
                end
            end
        end
    end

    // One RUN step: accumulate partial products, then advance multiplicand and multiplier.
    // The multiplicand never reaches a lane's top bit, so the j-shift cannot cross lanes.
    always_comb begin
        acc_d = acc_q;
        pp    = '0;
        for (int j = 0; j < BPC; j++) begin
            pp = (mcand_q << j) & bsel[j];
            if (clmul_q) begin
                acc_d = acc_d ^ pp;
            end else begin
                // Lane MSBs summed separately so no carry escapes a 2w-bit lane.
                acc_d = ((acc_d & ~lane_msb) + (pp & ~lane_msb)) ^ ((acc_d ^ pp) & lane_msb);
            end
        end
        mcand_d  = (mcand_q << BPC) & ~lane_bot;
        mplier_d = (mplier_q >> BPC) & ~lane_top;
`ifdef P_MUL_SEQ_EARLY_EXIT_EN
        run_last = (cnt_q == last_q) || (mplier_d == '0);
`else
        run_last = (cnt_q == last_q);
`endif
    end

    // Control FSM with registered ready/result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            last_q   <= '0;
            pw_q     <= '0;
            clmul_q  <= 1'b0;
            mul_l_q  <= 1'b0;
            mul_h_q  <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            ready    <= 1'b0;
            result   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    ready <= 1'b0;
                    // The requester still holds valid during the ready cycle; skip it.
                    if (valid && !ready) begin
                        state_q  <= StRun;
                        cnt_q    <= '0;
                        last_q   <= last_d;
                        pw_q     <= pw_sel;
                        clmul_q  <= clmul;
                        mul_l_q  <= mul_l;
                        mul_h_q  <= mul_h;
                        mcand_q  <= load_a;
                        mplier_q <= load_b;
                        acc_q    <= '0;
                    end
                end
                StRun: begin
                    if (!valid) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_d;
                        mplier_q <= mplier_d;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (run_last) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    if (valid) begin
                        ready  <= 1'b1;
                        result <= mul_l_q ? acc_lo : (mul_h_q ? acc_hi : '0);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
